snake_motion_engine: RTL
========================

// Module: snake_motion_engine
// PURPOSE
//   Drives snake head/body coordinates consumed by collision_detector and reacts to its flags.
//   Steps the snake one cell per game tick in the latched direction and rejects 180-degree reversals.
//   Sequences IDLE -> RUN -> DEAD.
// PARAMETERS
//   TICK_DIV  4  clk cycles per movement step (>=1; 1 = step every cycle)
//   INIT_X    4  reset/restart head x; body1 = INIT_X-1, body2 = INIT_X-2; all at y=INIT_Y (INIT_X>=2)
//   INIT_Y    4  reset/restart row for head and body
// PORTS
//   clk             in   1  system clock, rising edge
//   rst             in   1  asynchronous, active-high reset
//   start           in   1  level; IDLE->RUN, DEAD->restart
//   dir_in          in   2  requested direction: 00 up(y-1) 01 down(y+1) 10 left(x-1) 11 right(x+1)
//   dir_valid       in   1  dir_in qualifier, sampled every cycle
//   wall_collision  in   1  from collision_detector
//   self_collision  in   1  from collision_detector
//   head_x, head_y  out  3  registered head cell
//   body1_x,body1_y out  3  registered segment behind head
//   body2_x,body2_y out  3  registered tail segment
//   step            out  1  one-cycle pulse, the cycle after positions update
//   alive           out  1  1 in RUN
//   game_over       out  1  1 in DEAD
// BEHAVIOUR
//   Reset: state IDLE, head=(INIT_X,INIT_Y), body1=(INIT_X-1,INIT_Y), body2=(INIT_X-2,INIT_Y).
//     dir=cur=pending=RIGHT, tick_cnt=0, step=0, alive=0, game_over=0. rst mid-run aborts at once to these values.
//   IDLE: positions held; start=1 -> RUN next cycle, tick_cnt=0.
//   RUN: tick_cnt counts 0..TICK_DIV-1 and wraps; terminal count = move cycle.
//     Move: body2<=body1, body1<=head, head<=head+delta(pending), cur_dir<=pending; step=1 next cycle.
//     First move occurs TICK_DIV cycles after entering RUN.
//   Direction: dir_valid=1 and dir_in != (cur_dir ^ 2'b01) -> pending<=dir_in; reversal silently dropped.
//     Several requests between moves: last accepted wins. Reversal check is against cur_dir, not pending.
//     Request on the move cycle itself applies to the following move.
//   Collision: wall_collision|self_collision sampled every RUN cycle -> DEAD next cycle, no move.
//     Collision beats move on the same cycle: positions frozen at the colliding values.
//   Arithmetic: 3-bit coords, grid 0..7; delta computed in 4 bits to detect edge crossing.
//   DEAD: positions and cur_dir held, tick_cnt frozen, game_over=1.
//     start=1 -> reload init positions, dir=RIGHT, tick_cnt=0 -> RUN next cycle.
//   start in RUN: ignored. dir_valid in IDLE/DEAD: ignored.
// CONFIGURATION
//   SNAKE_WRAP_AROUND_EN defined: moves past an edge wrap modulo 8 (x=7 right -> x=0; y=0 up -> y=7).
//     Only self_collision and wall_collision can end the game.
//   Not defined: a move that would leave 0..7 is suppressed.
//     Positions are held and state -> DEAD next cycle (internal wall hit), identical to a wall_collision.
//     This is required because the downstream wall check cannot see out-of-range 3-bit values.
// STRUCTURE
//   snake_pkg: DIR_UP/DIR_DOWN/DIR_LEFT/DIR_RIGHT encodings, ST_IDLE/ST_RUN/ST_DEAD state encodings, GRID_MAX=7.
//   Sub-module snake_tick_gen(clk,rst,en,clr,tick) holds the TICK_DIV counter; the engine keeps FSM, direction and position registers.
// TESTING
//   1. rst, TICK_DIV=4, start -> first step pulse at cycle 5 after start; head (5,4), body1 (4,4), body2 (3,4).
//   2. cur=RIGHT, dir_in=LEFT with dir_valid -> ignored, head keeps x+1. dir_in=UP -> next move head y-1.
//   3. Head at (7,4) moving RIGHT: wrap build -> head (0,4), alive=1. Non-wrap build -> head stays (7,4), game_over=1 next cycle.
//   4. Force self_collision=1 on the terminal-count cycle -> no position change, DEAD next cycle, step never pulses.
//   5. DEAD, start=1 -> head (4,4), body (3,4),(2,4), dir RIGHT, alive=1 next cycle.
//   6. Assert rst mid-RUN between ticks -> all outputs at reset values within the same cycle (async); IDLE after release.

Source files
------------

// File: rtl/snake_pkg.sv
// rtl/snake_pkg.sv - direction/state encodings and the head-advance helper for the snake engine
package snake_pkg;

    localparam logic [1:0] DIR_UP    = 2'b00;
    localparam logic [1:0] DIR_DOWN  = 2'b01;
    localparam logic [1:0] DIR_LEFT  = 2'b10;
    localparam logic [1:0] DIR_RIGHT = 2'b11;

    localparam logic [3:0] GRID_MAX = 4'd7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DEAD = 2'b10
    } state_t;

    // Returns {x[3:0], y[3:0]}; the extra bit exposes a step off either edge of the grid.
    function automatic logic [7:0] next_cell(input logic [2:0] x, input logic [2:0] y,
                                             input logic [1:0] dir);
        logic [3:0] nx;
        logic [3:0] ny;
        nx = {1'b0, x};
        ny = {1'b0, y};
        case (dir)
            DIR_UP:   ny = ny - 4'd1;
            DIR_DOWN: ny = ny + 4'd1;
            DIR_LEFT: nx = nx - 4'd1;
            default:  nx = nx + 4'd1;
        endcase
        return {nx, ny};
    endfunction

endpackage

// File: rtl/snake_tick_gen.sv
// rtl/snake_tick_gen.sv - movement-step divider; tick marks the terminal-count cycle
module snake_tick_gen #(
    parameter int TICK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] TERM = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt;

    assign tick = en && (cnt == TERM);

    // Holds its value while disabled so the count is frozen outside RUN.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= tick ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/snake_motion_engine.sv
// rtl/snake_motion_engine.sv - snake head/body stepper and IDLE/RUN/DEAD sequencer; SNAKE_WRAP_AROUND_EN selects edge wrap
module snake_motion_engine
    import snake_pkg::*;
#(
    parameter int TICK_DIV = 4,
    parameter int INIT_X   = 4,
    parameter int INIT_Y   = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [1:0] dir_in,
    input  logic       dir_valid,
    input  logic       wall_collision,
    input  logic       self_collision,
    output logic [2:0] head_x,
    output logic [2:0] head_y,
    output logic [2:0] body1_x,
    output logic [2:0] body1_y,
    output logic [2:0] body2_x,
    output logic [2:0] body2_y,
    output logic       step,
    output logic       alive,
    output logic       game_over
);

`ifdef SNAKE_WRAP_AROUND_EN
    localparam bit WRAP_EN = 1'b1;
`else
    localparam bit WRAP_EN = 1'b0;
`endif

    localparam logic [2:0] IX  = 3'(INIT_X);
    localparam logic [2:0] IX1 = 3'(INIT_X - 1);
    localparam logic [2:0] IX2 = 3'(INIT_X - 2);
    localparam logic [2:0] IY  = 3'(INIT_Y);

    state_t     state, state_nxt;
    logic [1:0] cur_dir, pending;
    logic       tick, restart, do_move, edge_stop, dir_accept;
    logic [7:0] nc;

    snake_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .en   (state == ST_RUN),
        .clr  (restart),
        .tick (tick)
    );

    assign nc         = next_cell(head_x, head_y, pending);
    // Out-of-range values are invisible to the downstream wall check, so the engine stops itself.
    assign edge_stop  = ~WRAP_EN & ((nc[7:4] > GRID_MAX) | (nc[3:0] > GRID_MAX));
    assign dir_accept = (state == ST_RUN) && dir_valid && (dir_in != (cur_dir ^ 2'b01));
    assign alive      = (state == ST_RUN);
    assign game_over  = (state == ST_DEAD);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        restart   = 1'b0;
        do_move   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nxt = ST_RUN;
                    restart   = 1'b1;
                end
            end
            ST_RUN: begin
                if (wall_collision || self_collision) begin
                    state_nxt = ST_DEAD;
                end else if (tick) begin
                    if (edge_stop) begin
                        state_nxt = ST_DEAD;
                    end else begin
                        do_move = 1'b1;
                    end
                end
            end
            ST_DEAD: begin
                if (start) begin
                    state_nxt = ST_RUN;
                    restart   = 1'b1;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_x  <= IX;
            head_y  <= IY;
            body1_x <= IX1;
            body1_y <= IY;
            body2_x <= IX2;
            body2_y <= IY;
            cur_dir <= DIR_RIGHT;
            pending <= DIR_RIGHT;
            step    <= 1'b0;
        end else begin
            step <= do_move;
            if (restart) begin
                head_x  <= IX;
                head_y  <= IY;
                body1_x <= IX1;
                body1_y <= IY;
                body2_x <= IX2;
                body2_y <= IY;
                cur_dir <= DIR_RIGHT;
                pending <= DIR_RIGHT;
            end else begin
                if (do_move) begin
                    body2_x <= body1_x;
                    body2_y <= body1_y;
                    body1_x <= head_x;
                    body1_y <= head_y;
                    head_x  <= nc[6:4];
                    head_y  <= nc[2:0];
                    cur_dir <= pending;
                end
                if (dir_accept) begin
                    pending <= dir_in;
                end
            end
        end
    end

endmodule
